// File: rtl/rickv_pkg.sv
// Shared definitions for the RICK-V fetch stage: opcodes, fetch state
// encoding, instruction classes and branch/jump immediate extraction.
package rickv_pkg;

   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_PREDICT,
      ST_ISSUE,
      ST_JALR_WAIT,
      ST_REDIRECT
   } ifetch_state_e;

   typedef enum logic [1:0] {
      CLS_OTHER,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR
   } inst_class_e;

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/ifetch_predecode.sv
// Combinational pre-decode: opcode class plus the three candidate next-PC
// sums (pc+4, pc+immB, pc+immJ), all wrapping modulo 2^32.
module ifetch_predecode
   import rickv_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [31:0] inst,
   output inst_class_e cls,
   output logic [31:0] pc_plus4,
   output logic [31:0] pc_plus_immb,
   output logic [31:0] pc_plus_immj
);

   always_comb begin
      cls = CLS_OTHER;
      case (inst[6:0])
         OPC_BRANCH: cls = CLS_BRANCH;
         OPC_JAL:    cls = CLS_JAL;
         OPC_JALR:   cls = CLS_JALR;
         default:    cls = CLS_OTHER;
      endcase
   end

   assign pc_plus4     = pc + 32'd4;
   assign pc_plus_immb = pc + imm_b(inst);
   assign pc_plus_immj = pc + imm_j(inst);

endmodule

// File: rtl/ifetch.sv
// RICK-V instruction fetch stage. Build with IFETCH_PREDICT_EN to route
// conditional branches through the 2-bit predictor; otherwise static not-taken.
//
// state        | meaning
// FETCH        | icache request outstanding for pc
// PREDICT      | waiting one cycle for pred_result of a branch
// ISSUE        | instruction offered downstream until inst_ready
// JALR_WAIT    | fetch halted until flush supplies the JALR target
// REDIRECT     | one idle cycle so the cache drops the old access
module ifetch
   import rickv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   output logic        icache_req,
   output logic [31:0] icache_addr,
   input  logic        icache_valid,
   input  logic [31:0] icache_inst,
   output logic        pred_query,
   output logic [31:0] pred_pc,
   input  logic        pred_result,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_pred_taken,
   input  logic        inst_ready,
   input  logic        flush,
   input  logic [31:0] flush_pc
);

   ifetch_state_e state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   next_pc_q, next_pc_d;
   logic [31:0]   inst_q, inst_d;
   logic [31:0]   inst_pc_q, inst_pc_d;
   logic          taken_q, taken_d;
   logic          valid_q, valid_d;
   logic          is_jalr_q, is_jalr_d;

   inst_class_e   cls;
   logic [31:0]   pd_inst;
   logic [31:0]   pc_plus4;
   logic [31:0]   pc_plus_immb;
   logic [31:0]   pc_plus_immj;

   // In FETCH classify the word arriving from the cache; in PREDICT the latched one.
   assign pd_inst = (state_q == ST_FETCH) ? icache_inst : inst_q;

   ifetch_predecode u_predecode (
      .pc           (pc_q),
      .inst         (pd_inst),
      .cls          (cls),
      .pc_plus4     (pc_plus4),
      .pc_plus_immb (pc_plus_immb),
      .pc_plus_immj (pc_plus_immj)
   );

`ifndef IFETCH_PREDICT_EN
   logic unused_pred;
   assign unused_pred = ^{pred_result, pc_plus_immb};
`endif

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      next_pc_d  = next_pc_q;
      inst_d     = inst_q;
      inst_pc_d  = inst_pc_q;
      taken_d    = taken_q;
      valid_d    = valid_q;
      is_jalr_d  = is_jalr_q;
      pred_query = 1'b0;

      if (rdy) begin
         if (flush) begin
            state_d   = ST_REDIRECT;
            pc_d      = flush_pc;
            valid_d   = 1'b0;
            is_jalr_d = 1'b0;
         end else begin
            case (state_q)
               ST_FETCH: begin
                  if (icache_valid) begin
                     inst_d    = icache_inst;
                     inst_pc_d = pc_q;
                     is_jalr_d = 1'b0;
                     case (cls)
`ifdef IFETCH_PREDICT_EN
                        CLS_BRANCH: begin
                           pred_query = 1'b1;
                           state_d    = ST_PREDICT;
                        end
`endif
                        CLS_JAL: begin
                           next_pc_d = pc_plus_immj;
                           taken_d   = 1'b1;
                           valid_d   = 1'b1;
                           state_d   = ST_ISSUE;
                        end
                        default: begin
                           next_pc_d = pc_plus4;
                           taken_d   = 1'b0;
                           valid_d   = 1'b1;
                           is_jalr_d = (cls == CLS_JALR);
                           state_d   = ST_ISSUE;
                        end
                     endcase
                  end
               end
`ifdef IFETCH_PREDICT_EN
               ST_PREDICT: begin
                  taken_d   = pred_result;
                  next_pc_d = pred_result ? pc_plus_immb : pc_plus4;
                  valid_d   = 1'b1;
                  state_d   = ST_ISSUE;
               end
`endif
               ST_ISSUE: begin
                  if (inst_ready) begin
                     pc_d    = next_pc_q;
                     valid_d = 1'b0;
                     state_d = is_jalr_q ? ST_JALR_WAIT : ST_FETCH;
                  end
               end
               ST_JALR_WAIT: state_d = ST_JALR_WAIT;
               ST_REDIRECT:  state_d = ST_FETCH;
               default:      state_d = ST_FETCH;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         next_pc_q <= RESET_PC;
         inst_q    <= 32'h0;
         inst_pc_q <= 32'h0;
         taken_q   <= 1'b0;
         valid_q   <= 1'b0;
         is_jalr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         next_pc_q <= next_pc_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         taken_q   <= taken_d;
         valid_q   <= valid_d;
         is_jalr_q <= is_jalr_d;
      end
   end

   assign icache_req      = (state_q == ST_FETCH);
   assign icache_addr     = pc_q;
   assign pred_pc         = pc_q;
   assign inst_valid      = valid_q;
   assign inst            = inst_q;
   assign inst_pc         = inst_pc_q;
   assign inst_pred_taken = taken_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch; expectations are hand-computed constants and
// follow the IFETCH_PREDICT_EN build setting.
module tb_ifetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        icache_req;
   logic [31:0] icache_addr;
   logic        icache_valid;
   logic [31:0] icache_inst;
   logic        pred_query;
   logic [31:0] pred_pc;
   logic        pred_result;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_pred_taken;
   logic        inst_ready;
   logic        flush;
   logic [31:0] flush_pc;

   int checks = 0;
   int errors = 0;

   ifetch dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .icache_req      (icache_req),
      .icache_addr     (icache_addr),
      .icache_valid    (icache_valid),
      .icache_inst     (icache_inst),
      .pred_query      (pred_query),
      .pred_pc         (pred_pc),
      .pred_result     (pred_result),
      .inst_valid      (inst_valid),
      .inst            (inst),
      .inst_pc         (inst_pc),
      .inst_pred_taken (inst_pred_taken),
      .inst_ready      (inst_ready),
      .flush           (flush),
      .flush_pc        (flush_pc)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One full fetch -> (predict) -> issue -> accept round trip at pc p.
   task automatic serve(input logic [31:0] p, input logic [31:0] iw, input logic pr,
                        input logic [31:0] exp_taken, input logic [31:0] exp_next);
      logic expq;
      logic isjalr;
`ifdef IFETCH_PREDICT_EN
      expq = (iw[6:0] == 7'b1100011);
`else
      expq = 1'b0;
`endif
      isjalr = (iw[6:0] == 7'b1100111);
      chk("fetch_req", {31'b0, icache_req}, 32'd1);
      chk("fetch_addr", icache_addr, p);
      icache_valid = 1'b1;
      icache_inst  = iw;
      #1;
      chk("pred_query", {31'b0, pred_query}, {31'b0, expq});
      if (expq) chk("pred_pc", pred_pc, p);
      tick();
      icache_valid = 1'b0;
      if (expq) begin
         chk("predict_no_valid", {31'b0, inst_valid}, 32'd0);
         pred_result = pr;
         tick();
         pred_result = 1'b0;
      end
      chk("inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("inst", inst, iw);
      chk("inst_pc", inst_pc, p);
      chk("inst_taken", {31'b0, inst_pred_taken}, exp_taken);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("valid_after_accept", {31'b0, inst_valid}, 32'd0);
      if (isjalr) begin
         chk("jalr_halt_req", {31'b0, icache_req}, 32'd0);
      end else begin
         chk("next_req", {31'b0, icache_req}, 32'd1);
         chk("next_addr", icache_addr, exp_next);
      end
   endtask

   task automatic redirect(input logic [31:0] p);
      flush    = 1'b1;
      flush_pc = p;
      tick();
      flush = 1'b0;
      chk("redirect_req_low", {31'b0, icache_req}, 32'd0);
      tick();
      chk("redirect_req", {31'b0, icache_req}, 32'd1);
      chk("redirect_addr", icache_addr, p);
   endtask

   initial begin
      rst          = 1'b1;
      rdy          = 1'b1;
      icache_valid = 1'b0;
      icache_inst  = 32'h0;
      pred_result  = 1'b0;
      inst_ready   = 1'b0;
      flush        = 1'b0;
      flush_pc     = 32'h0;
      #12;
      chk("rst_req", {31'b0, icache_req}, 32'd1);
      chk("rst_addr", icache_addr, 32'h0);
      chk("rst_pred_query", {31'b0, pred_query}, 32'd0);
      chk("rst_pred_pc", pred_pc, 32'h0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'h0);
      chk("rst_inst_pc", inst_pc, 32'h0);
      chk("rst_taken", {31'b0, inst_pred_taken}, 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // addi, addi, then JAL -8 at 0x8 back to 0x0
      serve(32'h0, 32'h0000_0013, 1'b0, 32'd0, 32'h4);
      serve(32'h4, 32'h0000_0013, 1'b0, 32'd0, 32'h8);
      serve(32'h8, 32'hFF9F_F06F, 1'b0, 32'd1, 32'h0);

      // flush during outstanding fetch; late icache_valid in REDIRECT ignored
      flush    = 1'b1;
      flush_pc = 32'h10;
      tick();
      flush = 1'b0;
      chk("flush_fetch_req_low", {31'b0, icache_req}, 32'd0);
      chk("flush_fetch_valid", {31'b0, inst_valid}, 32'd0);
      icache_valid = 1'b1;
      icache_inst  = 32'h0000_0013;
      tick();
      icache_valid = 1'b0;
      chk("late_valid_ignored", {31'b0, inst_valid}, 32'd0);
      chk("resume_req", {31'b0, icache_req}, 32'd1);
      chk("resume_addr", icache_addr, 32'h10);

      // BEQ +16 at 0x10, taken then not-taken
`ifdef IFETCH_PREDICT_EN
      serve(32'h10, 32'h0000_0863, 1'b1, 32'd1, 32'h20);
      redirect(32'h10);
      serve(32'h10, 32'h0000_0863, 1'b0, 32'd0, 32'h14);
`else
      serve(32'h10, 32'h0000_0863, 1'b1, 32'd0, 32'h14);
`endif

      // JALR at 0x30 halts fetch until flush to 0x100
      redirect(32'h30);
      serve(32'h30, 32'h0000_8067, 1'b0, 32'd0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         icache_valid = 1'b1;
         tick();
         icache_valid = 1'b0;
         chk("jalr_wait_req", {31'b0, icache_req}, 32'd0);
         chk("jalr_wait_valid", {31'b0, inst_valid}, 32'd0);
      end
      redirect(32'h100);

      // flush while ISSUE is stalled, coincident with inst_ready
      icache_valid = 1'b1;
      icache_inst  = 32'h0000_0013;
      tick();
      icache_valid = 1'b0;
      chk("stall_valid", {31'b0, inst_valid}, 32'd1);
      tick();
      chk("stall_hold_valid", {31'b0, inst_valid}, 32'd1);
      chk("stall_hold_pc", inst_pc, 32'h100);
      flush      = 1'b1;
      flush_pc   = 32'h200;
      inst_ready = 1'b1;
      tick();
      flush      = 1'b0;
      inst_ready = 1'b0;
      chk("issue_flush_valid", {31'b0, inst_valid}, 32'd0);
      chk("issue_flush_req_low", {31'b0, icache_req}, 32'd0);
      tick();
      chk("issue_flush_req", {31'b0, icache_req}, 32'd1);
      chk("issue_flush_addr", icache_addr, 32'h200);

      // rdy low for 3 cycles with icache_valid pulses
`ifdef IFETCH_PREDICT_EN
      icache_valid = 1'b1;
      icache_inst  = 32'h0000_0863;
      #1;
      chk("frz_query", {31'b0, pred_query}, 32'd1);
      tick();
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         icache_valid = 1'b1;
         icache_inst  = 32'h0000_0013;
         #1;
         chk("frz_pred_query", {31'b0, pred_query}, 32'd0);
         chk("frz_valid", {31'b0, inst_valid}, 32'd0);
         chk("frz_req", {31'b0, icache_req}, 32'd0);
         tick();
      end
      icache_valid = 1'b0;
      rdy          = 1'b1;
      pred_result  = 1'b1;
      tick();
      pred_result = 1'b0;
      chk("frz_issue_valid", {31'b0, inst_valid}, 32'd1);
      chk("frz_issue_inst", inst, 32'h0000_0863);
      chk("frz_issue_pc", inst_pc, 32'h200);
      chk("frz_issue_taken", {31'b0, inst_pred_taken}, 32'd1);
      inst_ready = 1'b1;
      tick();
      inst_ready = 1'b0;
      chk("frz_next_addr", icache_addr, 32'h210);
`else
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         icache_valid = 1'b1;
         icache_inst  = 32'h0000_0863;
         #1;
         chk("frz_pred_query", {31'b0, pred_query}, 32'd0);
         chk("frz_req", {31'b0, icache_req}, 32'd1);
         chk("frz_addr", icache_addr, 32'h200);
         tick();
         chk("frz_valid", {31'b0, inst_valid}, 32'd0);
      end
      icache_valid = 1'b0;
      rdy          = 1'b1;
      serve(32'h200, 32'h0000_0863, 1'b1, 32'd0, 32'h204);
`endif

      // PC wrap at top of address space
      redirect(32'hFFFF_FFFC);
      serve(32'hFFFF_FFFC, 32'h0000_0013, 1'b0, 32'd0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage of the RICK-V out-of-order core. Holds the architectural fetch PC, requests 32-bit words from the instruction cache, pre-decodes branch/jump opcodes, queries the 2-bit branch predictor for conditional branches, and presents one instruction per handshake to the decoder/issue stage. Redirects on ROB flush; stalls on JALR until the resolved target arrives via flush.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC after reset
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rdy  in  1  global ready; low freezes all state
- icache_req  out  1  fetch request, held until icache_valid
- icache_addr  out  32  word address of request (= pc)
- icache_valid  in  1  one-cycle pulse, icache_inst valid
- icache_inst  in  32  fetched instruction
- pred_query  out  1  combinational predictor query strobe
- pred_pc  out  32  PC of queried branch (= pc)
- pred_result  in  1  predictor output, valid the cycle after pred_query
- inst_valid  out  1  instruction offered downstream
- inst  out  32  instruction word
- inst_pc  out  32  its PC
- inst_pred_taken  out  1  predicted direction (JAL = 1, others 0 unless predicted)
- inst_ready  in  1  downstream can accept
- flush  in  1  redirect (mispredict or JALR resolve)
- flush_pc  in  32  redirect target

## Operation
- States: FETCH, PREDICT, ISSUE, JALR_WAIT, REDIRECT. Reset -> FETCH, pc = RESET_PC.
- FETCH: icache_req = 1, icache_addr = pc. On icache_valid latch inst/inst_pc, classify opcode:
  - BRANCH (7'b1100011): pred_query = 1 that same cycle, pred_pc = pc; -> PREDICT.
  - JAL (7'b1101111): next_pc = pc + immJ, pred_taken = 1; -> ISSUE.
  - JALR (7'b1100111) and all others: next_pc = pc + 4, pred_taken = 0; -> ISSUE.
- PREDICT (1 cycle): pred_taken = pred_result; next_pc = taken ? pc + immB : pc + 4; -> ISSUE.
- ISSUE: inst_valid = 1, outputs stable until inst_ready. On inst_valid && inst_ready: pc <= next_pc; -> JALR_WAIT if JALR else FETCH.
- JALR_WAIT: no requests; leaves only via flush.
- REDIRECT: icache_req = 0 for exactly one cycle (cache abandons outstanding access); icache_valid ignored; -> FETCH.
- flush in any state: highest priority; pc <= flush_pc, inst_valid <= 0, latched instruction dropped, -> REDIRECT. flush with inst_ready in ISSUE: flush wins; downstream is flushed same cycle, acceptance irrelevant.
- Arithmetic: immB/immJ sign-extended to 32 bits, all PC sums modulo 2^32 (wrap at 32'hFFFF_FFFC + 4 = 0).
- rdy low: no register updates, pred_query forced 0, icache_valid/flush/inst_ready ignored; combinational outputs otherwise reflect frozen state.

## Timing
- Reset values: icache_req 1 (state FETCH, comb), icache_addr RESET_PC, pred_query 0, pred_pc RESET_PC, inst_valid 0, inst 0, inst_pc 0, inst_pred_taken 0.
- Non-branch: icache_valid in cycle N -> inst_valid in N+1.
- Branch: icache_valid + pred_query in N, PREDICT in N+1, inst_valid in N+2.
- Handshake completes in ISSUE at inst_ready; next icache_req the following cycle.
- Flush in N: REDIRECT in N+1 (req low), icache_req high with flush_pc in N+2.
- inst_valid, inst, inst_pc, inst_pred_taken are registered.

## Configuration
- IFETCH_PREDICT_EN defined: BRANCH flow as above via predictor.
- Undefined: pred_query tied 0, PREDICT state removed; BRANCH treated static not-taken (next_pc = pc + 4, inst_pred_taken = 0), latency as non-branch.

## Structure
- Shared package rickv_pkg: opcode constants OPC_BRANCH, OPC_JAL, OPC_JALR; ifetch state enum; immB/immJ extract functions.
- Sub-module ifetch_predecode: combinational opcode classification, immediate extraction, target adders (pc+4, pc+imm).

## Test plan
- Reset, RESET_PC=0: icache_addr 0, icache_req 1; return 32'h00000013 (addi) -> inst_valid next cycle, inst_pc 0, next request 0x4.
- BEQ at 0x10, imm +16, pred_result 1 -> pred_query/pred_pc 0x10 same cycle as icache_valid, inst_pred_taken 1, next fetch 0x20; pred_result 0 -> next 0x14.
- JAL at 0x8 imm -8 -> inst_pred_taken 1, next fetch 0x0, no pred_query.
- JALR at 0x30 -> issued, fetch halts; flush_pc 0x100 -> one cycle req low, then fetch 0x100.
- Flush while ISSUE stalled (inst_ready 0) and during outstanding FETCH -> inst_valid drops next cycle, late icache_valid in REDIRECT ignored, fetch resumes at flush_pc.
- rdy low 3 cycles mid-PREDICT with icache_valid pulse -> no state change; resumes identically; without IFETCH_PREDICT_EN, BEQ issues with taken 0, next pc+4.
